// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: control codes, main-control
// op classes, R-type function fields and the execution FSM state type.
package alu_pkg;

    localparam int unsigned CTL_W = 4;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned FN_W  = 6;

    // ALU control codes carried with each result
    localparam logic [CTL_W-1:0] CTL_AND = 4'b0000;
    localparam logic [CTL_W-1:0] CTL_OR  = 4'b0001;
    localparam logic [CTL_W-1:0] CTL_ADD = 4'b0010;
    localparam logic [CTL_W-1:0] CTL_SUB = 4'b0110;
    localparam logic [CTL_W-1:0] CTL_SLT = 4'b0111;
    localparam logic [CTL_W-1:0] CTL_MUL = 4'b1000;
    localparam logic [CTL_W-1:0] CTL_NOR = 4'b1100;
    localparam logic [CTL_W-1:0] CTL_ILL = 4'b1111;

    // Main-control op classes
    localparam logic [OP_W-1:0] OP_ADD   = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB   = 2'b01;
    localparam logic [OP_W-1:0] OP_RTYPE = 2'b10;

    // R-type function fields
    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FN_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FN_W-1:0] FN_MUL = 6'b011000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU control decoder.
// Ports: i_alu_op/i_func_code in; o_alu_ctl control code, o_is_mul for the
// multi-cycle multiply, o_illegal for any undecodable request (ctl 1111).
module alu_ctl_decode
    import alu_pkg::*;
#(
    parameter int unsigned MUL_EN = 1
) (
    input  logic [OP_W-1:0]  i_alu_op,
    input  logic [FN_W-1:0]  i_func_code,
    output logic [CTL_W-1:0] o_alu_ctl,
    output logic             o_is_mul,
    output logic             o_illegal
);

    // Default everything to the illegal encoding; legal cases override
    always_comb begin
        o_alu_ctl = CTL_ILL;
        o_is_mul  = 1'b0;
        o_illegal = 1'b1;
        case (i_alu_op)
            OP_ADD: begin o_alu_ctl = CTL_ADD; o_illegal = 1'b0; end
            OP_SUB: begin o_alu_ctl = CTL_SUB; o_illegal = 1'b0; end
            OP_RTYPE: begin
                case (i_func_code)
                    FN_ADD: begin o_alu_ctl = CTL_ADD; o_illegal = 1'b0; end
                    FN_SUB: begin o_alu_ctl = CTL_SUB; o_illegal = 1'b0; end
                    FN_AND: begin o_alu_ctl = CTL_AND; o_illegal = 1'b0; end
                    FN_OR:  begin o_alu_ctl = CTL_OR;  o_illegal = 1'b0; end
                    FN_SLT: begin o_alu_ctl = CTL_SLT; o_illegal = 1'b0; end
                    FN_NOR: begin o_alu_ctl = CTL_NOR; o_illegal = 1'b0; end
                    FN_MUL: begin
                        if (MUL_EN != 0) begin
                            o_alu_ctl = CTL_MUL;
                            o_is_mul  = 1'b1;
                            o_illegal = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake on both sides.
// Single-cycle ops complete one cycle after accept; multiply is a serial
// shift-add taking WIDTH steps. Result, zero, alu_ctl and illegal are held
// while out_valid is high and the consumer stalls.
// Ports: clk, rst (async active-high); in_valid/in_ready, alu_op, func_code,
// op_a, op_b request side; out_valid/out_ready, result, zero, alu_ctl,
// illegal result side.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [FN_W-1:0]  func_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [CTL_W-1:0] alu_ctl,
    output logic             illegal
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [CTL_W-1:0]   r_ctl;
    logic               r_illegal;

    logic [CTL_W-1:0]   w_ctl;
    logic               w_is_mul;
    logic               w_illegal;
    logic               w_accept;
    logic               w_mul_last;
    logic [WIDTH-1:0]   w_alu_res;
    logic [WIDTH-1:0]   w_acc_step;

    alu_ctl_decode #(
        .MUL_EN (MUL_EN)
    ) u_decode (
        .i_alu_op    (alu_op),
        .i_func_code (func_code),
        .o_alu_ctl   (w_ctl),
        .o_is_mul    (w_is_mul),
        .o_illegal   (w_illegal)
    );

    assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign out_valid  = (r_state == ST_DONE);
    assign w_accept   = in_valid && in_ready;
    // Last shift-add step: its sum is the final product
    assign w_mul_last = (r_state == ST_MUL) && (r_cnt == CNT_W'(1));
    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign result  = r_result;
    assign zero    = r_zero;
    assign alu_ctl = r_ctl;
    assign illegal = r_illegal;

    // Single-cycle datapath; illegal and mul codes produce 0 here
    always_comb begin
        w_alu_res = '0;
        case (w_ctl)
            CTL_ADD: w_alu_res = op_a + op_b;
            CTL_SUB: w_alu_res = op_a - op_b;
            CTL_AND: w_alu_res = op_a & op_b;
            CTL_OR:  w_alu_res = op_a | op_b;
            CTL_NOR: w_alu_res = ~(op_a | op_b);
            CTL_SLT: w_alu_res = WIDTH'($signed(op_a) < $signed(op_b));
            default: w_alu_res = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
            end
            ST_MUL: begin
                if (w_mul_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
                    else          w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Multiplier and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_ctl     <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept && w_is_mul) begin
                r_cnt    <= CNT_W'(WIDTH);
                r_acc    <= '0;
                r_mcand  <= op_a;
                r_mplier <= op_b;
            end else if (r_state == ST_MUL) begin
                r_cnt    <= r_cnt - CNT_W'(1);
                r_acc    <= w_acc_step;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end

            if (w_accept && !w_is_mul) begin
                r_result  <= w_alu_res;
                r_zero    <= (w_alu_res == '0);
                r_ctl     <= w_ctl;
                r_illegal <= w_illegal;
            end else if (w_mul_last) begin
                r_result  <= w_acc_step;
                r_zero    <= (w_acc_step == '0);
                r_ctl     <= CTL_MUL;
                r_illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: transaction-level reference model
// (expected results with their due cycle) compared against the DUT each cycle.
module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]    alu_op = '0;
    logic [5:0]    func_code = '0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic          in_ready, out_valid, zero, illegal;
    logic [W-1:0]  result;
    logic [3:0]    alu_ctl;

    logic          nm_in_valid = 1'b0, nm_out_ready = 1'b0;
    logic [1:0]    nm_alu_op = '0;
    logic [5:0]    nm_func_code = '0;
    logic [W-1:0]  nm_op_a = '0, nm_op_b = '0;
    logic          nm_in_ready, nm_out_valid, nm_zero, nm_illegal;
    logic [W-1:0]  nm_result;
    logic [3:0]    nm_alu_ctl;

    alu_exec_unit #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .func_code(func_code), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .alu_ctl(alu_ctl), .illegal(illegal)
    );

    alu_exec_unit #(.WIDTH(W), .MUL_EN(0)) dut_nm (
        .clk(clk), .rst(rst), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .alu_op(nm_alu_op), .func_code(nm_func_code), .op_a(nm_op_a), .op_b(nm_op_b),
        .out_valid(nm_out_valid), .out_ready(nm_out_ready), .result(nm_result),
        .zero(nm_zero), .alu_ctl(nm_alu_ctl), .illegal(nm_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   c;
        bit           ill;
        int           rdy;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   hs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference behaviour of one request, straight from the op tables
    function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] c,
                                  output bit ill, output bit mul);
        r = '0; c = 4'hF; ill = 1'b1; mul = 1'b0;
        if (op == 2'b00) begin r = a + b; c = 4'h2; ill = 0; end
        else if (op == 2'b01) begin r = a - b; c = 4'h6; ill = 0; end
        else if (op == 2'b10) begin
            case (fn)
                6'h20: begin r = a + b;     c = 4'h2; ill = 0; end
                6'h22: begin r = a - b;     c = 4'h6; ill = 0; end
                6'h24: begin r = a & b;     c = 4'h0; ill = 0; end
                6'h25: begin r = a | b;     c = 4'h1; ill = 0; end
                6'h27: begin r = ~(a | b);  c = 4'hC; ill = 0; end
                6'h2A: begin r = ($signed(a) < $signed(b)) ? 1 : 0; c = 4'h7; ill = 0; end
                6'h18: begin r = a * b;     c = 4'h8; ill = 0; mul = 1; end
                default: ;
            endcase
        end
    endfunction

    // One clock cycle: drive inputs at negedge, compare against the model,
    // then advance the model across the coming rising edge.
    task automatic cycle(input logic iv, input logic ordy, input logic [1:0] op,
                         input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] r;
        logic [3:0] c;
        bit il, mu, ev, eir;
        in_valid = iv; out_ready = ordy; alu_op = op; func_code = fn; op_a = a; op_b = b;
        #1;
        ev  = (q.size() > 0) && (cyc >= q[0].rdy);
        eir = (q.size() == 0) || (ev && ordy);
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(eir));
        if (ev) begin
            chk("result", 64'(result), 64'(q[0].r));
            chk("alu_ctl", 64'(alu_ctl), 64'(q[0].c));
            chk("illegal", 64'(illegal), 64'(q[0].ill));
            chk("zero", 64'(zero), 64'(q[0].r == 0));
        end
        if (ev && ordy) begin
            void'(q.pop_front());
            hs++;
        end
        if (iv && eir) begin
            model(op, fn, a, b, r, c, il, mu);
            e.r = r; e.c = c; e.ill = il;
            e.rdy = cyc + (mu ? W + 1 : 1);
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [5:0] fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h18};

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lowc;
        int hs0;
        logic [W-1:0] snap;
        logic [1:0] rop;
        logic [5:0] rfn;
        int k;

        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_alu_ctl", 64'(alu_ctl), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Pinned literal cases
        cycle(1, 1, 2'b10, 6'h20, 7, 5);
        chk("lit_add_valid", 64'(out_valid), 64'd1);
        chk("lit_add_result", 64'(result), 64'd12);
        chk("lit_add_ctl", 64'(alu_ctl), 64'h2);
        chk("lit_add_zero", 64'(zero), 64'd0);
        cycle(1, 1, 2'b10, 6'h2A, 32'hFFFF_FFFF, 1);
        chk("lit_slt_result", 64'(result), 64'd1);
        chk("lit_slt_ctl", 64'(alu_ctl), 64'h7);
        cycle(1, 1, 2'b01, 6'h00, 9, 9);
        chk("lit_sub_result", 64'(result), 64'd0);
        chk("lit_sub_zero", 64'(zero), 64'd1);
        chk("lit_sub_ctl", 64'(alu_ctl), 64'h6);

        // Multiply latency and value
        cycle(1, 1, 2'b10, 6'h18, 6, 7);
        lowc = 0;
        for (k = 0; k < 40 && !out_valid; k++) begin
            if (!in_ready) lowc++;
            cycle(0, 0, 2'b00, 6'h00, W'($urandom), W'($urandom));
        end
        chk("mul_busy_cycles", 64'(lowc), 64'd32);
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_result", 64'(result), 64'd42);
        chk("mul_ctl", 64'(alu_ctl), 64'h8);

        // Backpressure hold, then back-to-back adds
        snap = result;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 2'b00, 6'h00, W'($urandom), W'($urandom));
            chk("hold_result", 64'(result), 64'(snap));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        hs0 = hs;
        for (int i = 0; i < 4; i++) cycle(1, 1, 2'b00, 6'h00, W'(i + 1), 100);
        cycle(0, 1, 2'b00, 6'h00, 0, 0);
        chk("b2b_handshakes", 64'(hs - hs0), 64'd5);

        // Multiply disabled: decodes as illegal
        nm_in_valid = 1; nm_alu_op = 2'b10; nm_func_code = 6'h18; nm_op_a = 6; nm_op_b = 7;
        #1 chk("nm_in_ready", 64'(nm_in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        nm_in_valid = 0; nm_out_ready = 1;
        #1;
        chk("nm_valid", 64'(nm_out_valid), 64'd1);
        chk("nm_illegal", 64'(nm_illegal), 64'd1);
        chk("nm_ctl", 64'(nm_alu_ctl), 64'hF);
        chk("nm_result", 64'(nm_result), 64'd0);
        chk("nm_zero", 64'(nm_zero), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("nm_idle", 64'(nm_out_valid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            rop = (k < 2) ? 2'b00 : (k < 4) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
            k = $urandom_range(0, 7);
            rfn = (k == 7) ? 6'($urandom) : fn_tab[k];
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rop, rfn,
                  pick_operand(), pick_operand());
        end
        for (k = 0; k < 100 && q.size() > 0; k++) cycle(0, 1, 2'b00, 6'h00, 0, 0);
        chk("drain_empty", 64'(q.size()), 64'd0);

        // Reset in the middle of a multiply
        cycle(1, 1, 2'b00, 6'h00, 3, 4);
        cycle(1, 1, 2'b10, 6'h18, 123, 456);
        for (int i = 0; i < 9; i++) cycle(0, 1, 2'b00, 6'h00, 0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_ctl", 64'(alu_ctl), 64'd0);
        chk("mid_rst_zero", 64'(zero), 64'd0);
        chk("mid_rst_illegal", 64'(illegal), 64'd0);
        q.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 40; i++) cycle(0, 1, 2'b00, 6'h00, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal 8..64).
REQ-002 SHALL have parameter MUL_EN, default 1; 1 enables the multi-cycle multiply, 0 decodes it as illegal.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit accepts request this cycle.
REQ-007 SHALL have port alu_op  input  2  main-control op class.
REQ-008 SHALL have port func_code  input  6  R-type function field.
REQ-009 SHALL have port op_a  input  WIDTH  first operand.
REQ-010 SHALL have port op_b  input  WIDTH  second operand.
REQ-011 SHALL have port out_valid  output  1  result held and valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  WIDTH  operation result.
REQ-014 SHALL have port zero  output  1  result == 0.
REQ-015 SHALL have port alu_ctl  output  4  control code of the held result.
REQ-016 SHALL have port illegal  output  1  held result came from an undecodable request.

Function
REQ-017 Decode SHALL be fully specified (no latched/held value): alu_op 00 -> add 0010; 01 -> sub 0110; 10 -> func 100000 add 0010, 100010 sub 0110, 100100 and 0000, 100101 or 0001, 101010 slt 0111, 100111 nor 1100, 011000 mul 1000 (MUL_EN=1 only); all else illegal 1111.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; slt signed two's-complement, result 1 or 0; mul returns low WIDTH bits of op_a*op_b.
REQ-019 Illegal request SHALL be accepted, complete in 1 cycle with result 0, alu_ctl 1111, illegal 1.
REQ-020 States SHALL be IDLE, MUL, DONE.
REQ-021 Transfer SHALL occur on in_valid && in_ready; in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-022 Non-mul accept SHALL go to DONE with result registered; out_valid high on the edge after accept (latency 1).
REQ-023 Mul accept SHALL latch operands, load counter WIDTH, go to MUL; one shift-add step per cycle; DONE entered when counter reaches 0; out_valid rises WIDTH+1 cycles after accept; in_ready low throughout MUL.
REQ-024 DONE: result, zero, alu_ctl, illegal SHALL hold stable while out_valid && !out_ready.
REQ-025 DONE with out_ready and in_valid SHALL retire current result and accept the new request in the same cycle (throughput 1 for non-mul).
REQ-026 DONE with out_ready and !in_valid SHALL return to IDLE, out_valid low next cycle.
REQ-027 Inputs SHALL be ignored when not transferring; operand change during MUL SHALL not affect result.

Reset
REQ-028 rst SHALL immediately force state IDLE, counter 0, out_valid 0, result 0, zero 0, alu_ctl 0000, illegal 0.
REQ-029 rst during MUL or DONE SHALL abort and discard the operation; no out_valid follows.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 Package alu_pkg SHALL hold alu_ctl codes, alu_op encodings, func_code constants, state enum.
REQ-032 Decode SHALL be a combinational sub-module alu_ctl_decode (alu_op, func_code, MUL_EN -> alu_ctl, is_mul, illegal).

Verification
REQ-033 WIDTH=32: alu_op 10, func 100000, a=7, b=5 -> next cycle out_valid, result 12, alu_ctl 0010, zero 0.
REQ-034 alu_op 10, func 101010, a=0xFFFFFFFF, b=1 -> result 1 (signed); alu_op 01, a=b=9 -> result 0, zero 1.
REQ-035 func 011000, a=6, b=7 -> in_ready low 32 cycles, out_valid on cycle 33, result 42, alu_ctl 1000; MUL_EN=0 same stimulus -> illegal 1, alu_ctl 1111.
REQ-036 out_ready held low 5 cycles after a result -> outputs stable, in_ready low; then back-to-back 4 adds with out_ready high -> 4 results on 4 consecutive cycles.
REQ-037 rst pulsed mid-multiply (cycle 10) -> outputs at reset values immediately, no out_valid afterwards, in_ready 1 after release.
